// File: rtl/branch_resolve_unit_pkg.sv
// Shared types for EX-stage branch resolution: operand word, branch opcode, BHT reset value.
package branch_resolve_unit_pkg;

   localparam int XLEN = 32;

   typedef logic [XLEN-1:0] word_t;

   typedef enum logic [3:0] {
      BR_NONE = 4'd0,
      BR_EQ   = 4'd1,
      BR_NE   = 4'd2,
      BR_LT   = 4'd3,
      BR_GE   = 4'd4,
      BR_LTU  = 4'd5,
      BR_GEU  = 4'd6,
      BR_JAL  = 4'd7,
      BR_JALR = 4'd8
   } br_op_t;

   localparam logic [1:0] BHT_WEAK_NT = 2'b01;

   function automatic logic is_cond_op(input br_op_t op);
      return op inside {BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU};
   endfunction

endpackage

// File: rtl/branch_resolve_unit_bht.sv
// 2-bit saturating branch history table: combinational read port, synchronous write port.
module bht_2bit
   import branch_resolve_unit_pkg::*;
#(
   parameter int DEPTH = 16,
   localparam int IW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [IW-1:0] rd_idx_i,
   output logic          rd_taken_o,
   input  logic          wr_en_i,
   input  logic [IW-1:0] wr_idx_i,
   input  logic          wr_taken_i
);

   logic [1:0] ctr_q [DEPTH];
   logic [1:0] ctr_d [DEPTH];

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_entry
         logic hit;
         assign hit = wr_en_i && (wr_idx_i == IW'(gi));
         // Saturate at 2'b11 when taken, 2'b00 when not taken.
         assign ctr_d[gi] = !hit                            ? ctr_q[gi] :
                            (wr_taken_i  && ctr_q[gi] != 2'b11) ? ctr_q[gi] + 2'd1 :
                            (!wr_taken_i && ctr_q[gi] != 2'b00) ? ctr_q[gi] - 2'd1 :
                                                                  ctr_q[gi];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) ctr_q[i] <= BHT_WEAK_NT;
      end else begin
         for (int i = 0; i < DEPTH; i++) ctr_q[i] <= ctr_d[i];
      end
   end

   // Reading the register array gives the pre-update value on a same-index write.
   assign rd_taken_o = ctr_q[rd_idx_i][1];

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch/jump resolver: condition evaluation, mispredict redirect, timed flush,
// BHT training and saturating performance counters.
module branch_resolve_unit
   import branch_resolve_unit_pkg::*;
#(
   parameter int BHT_DEPTH    = 16,
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid_ex,
   input  logic             stall,
   input  br_op_t           br_op_ex,
   input  word_t            pc_ex,
   input  word_t            imm_ex,
   input  word_t            rs1_ex,
   input  word_t            rs2_ex,
   input  logic             pred_taken_ex,
   input  word_t            pc_if,
   output logic             pred_taken_if,
   output logic             redirect,
   output word_t            redirect_pc,
   output logic             flush,
   output logic [CNT_W-1:0] branch_cnt,
   output logic [CNT_W-1:0] mispred_cnt
);

   localparam int IW      = $clog2(BHT_DEPTH);
   localparam int FLUSH_W = $clog2(FLUSH_CYCLES + 1);

   logic               redirect_q, redirect_d;
   word_t              redirect_pc_q, redirect_pc_d;
   logic [FLUSH_W-1:0] flush_cnt_q, flush_cnt_d;
   logic [CNT_W-1:0]   branch_cnt_q, branch_cnt_d;
   logic [CNT_W-1:0]   mispred_cnt_q, mispred_cnt_d;

   logic  cond_op, jump_op, taken, resolve, cond_resolve, cond_mispred;
   word_t br_target, jalr_target, fall_pc;
   logic  unused_pc_if_bits;

   assign cond_op      = is_cond_op(br_op_ex);
   assign jump_op      = (br_op_ex == BR_JAL) || (br_op_ex == BR_JALR);
   assign resolve      = valid_ex && !stall && (br_op_ex != BR_NONE) && !flush;
   assign cond_resolve = resolve && cond_op;
   assign cond_mispred = cond_resolve && (taken != pred_taken_ex);

   assign br_target   = pc_ex + imm_ex;
   assign jalr_target = (rs1_ex + imm_ex) & ~word_t'(1);
   assign fall_pc     = pc_ex + word_t'(4);

   always_comb begin
      taken = 1'b0;
      unique case (br_op_ex)
         BR_EQ:   taken = (rs1_ex == rs2_ex);
         BR_NE:   taken = (rs1_ex != rs2_ex);
         BR_LT:   taken = ($signed(rs1_ex) <  $signed(rs2_ex));
         BR_GE:   taken = ($signed(rs1_ex) >= $signed(rs2_ex));
         BR_LTU:  taken = (rs1_ex <  rs2_ex);
         BR_GEU:  taken = (rs1_ex >= rs2_ex);
         default: taken = 1'b0;
      endcase
   end

   always_comb begin
      redirect_d    = (resolve && jump_op) || cond_mispred;
      redirect_pc_d = redirect_pc_q;
      if (resolve && br_op_ex == BR_JALR)    redirect_pc_d = jalr_target;
      else if (resolve && br_op_ex == BR_JAL) redirect_pc_d = br_target;
      else if (cond_mispred)                  redirect_pc_d = taken ? br_target : fall_pc;

      // Flush counter reloads only on a redirect and otherwise drains, even under stall.
      flush_cnt_d = flush_cnt_q;
      if (redirect_d)            flush_cnt_d = FLUSH_W'(FLUSH_CYCLES);
      else if (flush_cnt_q != 0) flush_cnt_d = flush_cnt_q - FLUSH_W'(1);

      branch_cnt_d  = branch_cnt_q;
      mispred_cnt_d = mispred_cnt_q;
      if (cond_resolve && branch_cnt_q != '1)  branch_cnt_d  = branch_cnt_q + CNT_W'(1);
      if (cond_mispred && mispred_cnt_q != '1) mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         redirect_q    <= 1'b0;
         redirect_pc_q <= '0;
         flush_cnt_q   <= '0;
         branch_cnt_q  <= '0;
         mispred_cnt_q <= '0;
      end else begin
         redirect_q    <= redirect_d;
         redirect_pc_q <= redirect_pc_d;
         flush_cnt_q   <= flush_cnt_d;
         branch_cnt_q  <= branch_cnt_d;
         mispred_cnt_q <= mispred_cnt_d;
      end
   end

   bht_2bit #(
      .DEPTH (BHT_DEPTH)
   ) u_bht (
      .clk        (clk),
      .rst        (rst),
      .rd_idx_i   (pc_if[2 +: IW]),
      .rd_taken_o (pred_taken_if),
      .wr_en_i    (cond_resolve),
      .wr_idx_i   (pc_ex[2 +: IW]),
      .wr_taken_i (taken)
   );

   assign unused_pc_if_bits = ^{pc_if[XLEN-1:IW+2], pc_if[1:0]};

   assign redirect    = redirect_q;
   assign redirect_pc = redirect_pc_q;
   assign flush       = (flush_cnt_q != '0);
   assign branch_cnt  = branch_cnt_q;
   assign mispred_cnt = mispred_cnt_q;

endmodule
